imem_loader: RTL

- Write-side counterpart to the instruction ROM.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver, and assembles bytes MSB-first into DATA_WIDTH-bit words.
- Writes the words to consecutive addresses of the instruction memory's write port, starting at address 0.
- Holds the processor in reset while loading and raises done when the image is complete.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_word_packer.sv | 60 ++++++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// The default widths and depth match the instruction ROM so that
// loader and ROM line up without overrides.
package imem_pkg;

  localparam int IMEM_DATA_WIDTH    = 32;
  localparam int IMEM_ADDRESS_WIDTH = 12;
  localparam int IMEM_DEPTH         = 4096;

  localparam int BYTES_PER_WORD = IMEM_DATA_WIDTH / 8;

  // Loader states (legacy-compatible plain constants)
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_LOAD  = 2'd1;
  localparam state_t S_CHECK = 2'd2;
  localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word packer: shifts accepted bytes in MSB-first and emits a
// one-cycle word_valid together with the completed word. The output word
// register is separate from the shift register so a new word can start
// assembling while the previous one is being written.
module imem_word_packer
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
  parameter int BPW        = BYTES_PER_WORD
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  take,
  input  logic [7:0]            byte_in,
  output logic                  last_byte,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CW-1:0]         cnt;

  // Next assembly value: previous bytes move up, the new byte enters at the bottom
  always_comb begin
    shifted = (shreg << 8) | DATA_WIDTH'(byte_in);
  end

  assign last_byte = (cnt == CW'(BPW - 1));

  // Byte counter, shift register and completed-word register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (take) begin
        if (last_byte) begin
          word       <= shifted;
          word_valid <= 1'b1;
          shreg      <= '0;
          cnt        <= '0;
        end else begin
          shreg <= shifted;
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream over valid/ready, packs it
// into words and writes them to consecutive addresses from 0, holding the
// CPU in reset while loading.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_LOAD  | accepting data bytes, writing one word per BPW bytes
// S_CHECK | accepting the single checksum byte (checksum build only)
// S_DONE  | image complete, done held, waiting for a new start
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH    = IMEM_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = IMEM_ADDRESS_WIDTH,
  parameter int DEPTH         = IMEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     wEn,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    dataOut,
  output logic                     busy,
  output logic                     done,
  output logic                     cpu_hold,
  output logic                     error
);

  localparam int CNT_W = ADDRESS_WIDTH + 1;

  state_t           state;
  logic [CNT_W-1:0] words_left;
  logic [CNT_W-1:0] n_clamped;
  logic             drain;
  logic             take;
  logic             pack_take;
  logic             pack_clear;
  logic             last_byte;
  logic             word_valid;
  logic             start_ok;

  assign take       = byte_valid && byte_ready;
  assign pack_take  = take && (state == S_LOAD);
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign pack_clear = start_ok;
  assign n_clamped  = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;

  imem_word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BPW        (DATA_WIDTH / 8)
  ) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pack_clear),
    .take       (pack_take),
    .byte_in    (byte_in),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (dataOut)
  );

  // The packer's word_valid is already the one-cycle write strobe
  assign wEn = word_valid;

  // Sequencing FSM, word down-counter and write address.
  // words_left counts words whose last byte has not yet been accepted; when
  // the final byte goes in, ready drops immediately and drain waits for the
  // matching write before leaving LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b0;
      addr       <= '0;
      words_left <= '0;
      drain      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done       <= 1'b0;
            addr       <= '0;
            words_left <= n_clamped;
            drain      <= 1'b0;
            if (n_clamped == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_LOAD;
              busy       <= 1'b1;
              cpu_hold   <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (take && last_byte) begin
            words_left <= words_left - CNT_W'(1);
            if (words_left == CNT_W'(1)) begin
              drain      <= 1'b1;
              byte_ready <= 1'b0;
            end
          end
          if (word_valid) begin
            if (drain) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state      <= S_CHECK;
              byte_ready <= 1'b1;
`else
              state    <= S_DONE;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else begin
              // Last word keeps its address so addr never passes DEPTH-1
              addr <= addr + ADDRESS_WIDTH'(1);
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (take) begin
            state      <= S_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b1;
          end
        end
`else
        S_CHECK: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       error_q;

  // Modulo-256 running sum of data bytes, compared with the trailing byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum     <= '0;
      error_q <= 1'b0;
    end else if (start_ok) begin
      sum     <= '0;
      error_q <= 1'b0;
    end else if (pack_take) begin
      sum <= sum + byte_in;
    end else if (take && (state == S_CHECK)) begin
      error_q <= (byte_in != sum);
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
